tetron_move_ctrl: RTL and testbench

Sequencer for the active falling tetromino. It accepts move, rotate and gravity requests and drives the shared rotation shaper with a candidate rotation. It walks the shaper's four block offsets through a board-occupancy query port, then commits or rejects the candidate. On a rejected gravity step it locks the piece, respawns it, and detects game over.

---
 rtl/tetron_move_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_tetron_move_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetron_move_ctrl.sv
// Move/rotate/gravity sequencer for the falling tetromino: builds a candidate
// placement, probes each shaper block against the board, then commits, locks or dies.
module tetron_move_ctrl #(
    parameter int BOARD_W   = 10,
    parameter int BOARD_H   = 20,
    parameter int SPAWN_ROW = 1,
    parameter int SPAWN_COL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spawn,
    input  logic       req_left,
    input  logic       req_right,
    input  logic       req_rot,
    input  logic       req_down,
    output logic       shp_active,
    output logic [2:0] shp_rotation,
    input  logic [4:0] blk1_voffset,
    input  logic [4:0] blk2_voffset,
    input  logic [4:0] blk3_voffset,
    input  logic [4:0] blk4_voffset,
    input  logic [4:0] blk1_hoffset,
    input  logic [4:0] blk2_hoffset,
    input  logic [4:0] blk3_hoffset,
    input  logic [4:0] blk4_hoffset,
    output logic       brd_rd,
    output logic [4:0] brd_row,
    output logic [3:0] brd_col,
    input  logic       brd_occ,
    output logic [4:0] piece_row,
    output logic [3:0] piece_col,
    output logic [2:0] piece_rot,
    output logic       alive,
    output logic       busy,
    output logic       lock,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {IDLE, SHAPE, QUERY, WAIT, DECIDE, DEAD} state_t;
    typedef enum logic [2:0] {K_SPAWN, K_ROT, K_LEFT, K_RIGHT, K_DOWN} kind_t;

    localparam logic signed [6:0] H7  = 7'(BOARD_H);
    localparam logic signed [6:0] W7  = 7'(BOARD_W);
    localparam logic signed [6:0] SR7 = 7'(SPAWN_ROW);
    localparam logic signed [6:0] SC7 = 7'(SPAWN_COL);

    state_t            state, state_n;
    kind_t             kind, kind_n;
    logic [1:0]        blk, blk_n;
    logic              coll, coll_n;
    logic signed [6:0] cand_row, cand_row_n, cand_col, cand_col_n;
    logic [2:0]        cand_rot, cand_rot_n;
    logic [4:0]        piece_row_n;
    logic [3:0]        piece_col_n;
    logic [2:0]        piece_rot_n;
    logic              alive_n, game_over_n;

    logic [4:0]        voff, hoff;
    logic signed [6:0] voff_x, hoff_x, q_row, q_col, base_row, base_col;
    logic              oob, req_any;

    always_comb begin
        case (blk)
            2'd0:    begin voff = blk1_voffset; hoff = blk1_hoffset; end
            2'd1:    begin voff = blk2_voffset; hoff = blk2_hoffset; end
            2'd2:    begin voff = blk3_voffset; hoff = blk3_hoffset; end
            default: begin voff = blk4_voffset; hoff = blk4_hoffset; end
        endcase
    end

    // Signed 7-bit arithmetic so off-board candidates (e.g. col -1) stay detectable.
    assign voff_x   = {{2{voff[4]}}, voff};
    assign hoff_x   = {{2{hoff[4]}}, hoff};
    assign q_row    = cand_row + voff_x;
    assign q_col    = cand_col + hoff_x;
    assign oob      = (q_row < 7'sd0) || (q_row >= H7) || (q_col < 7'sd0) || (q_col >= W7);
    assign base_row = {2'b00, piece_row};
    assign base_col = {3'b000, piece_col};
    assign req_any  = alive ? (req_rot | req_left | req_right | req_down) : spawn;

    assign busy         = (state == SHAPE) || (state == QUERY) || (state == WAIT) || (state == DECIDE);
    assign shp_active   = alive | busy;
    assign shp_rotation = busy ? cand_rot : piece_rot;
    assign state_dbg    = state;

    always_comb begin
        state_n     = state;
        kind_n      = kind;
        blk_n       = blk;
        coll_n      = coll;
        cand_row_n  = cand_row;
        cand_col_n  = cand_col;
        cand_rot_n  = cand_rot;
        piece_row_n = piece_row;
        piece_col_n = piece_col;
        piece_rot_n = piece_rot;
        alive_n     = alive;
        game_over_n = game_over;
        brd_rd      = 1'b0;
        brd_row     = 5'd0;
        brd_col     = 4'd0;
        lock        = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    blk_n   = 2'd0;
                    coll_n  = 1'b0;
                    state_n = SHAPE;
                    if (!alive) begin
                        kind_n     = K_SPAWN;
                        cand_row_n = SR7;
                        cand_col_n = SC7;
                        cand_rot_n = 3'd0;
                    end else begin
                        cand_row_n = base_row;
                        cand_col_n = base_col;
                        cand_rot_n = piece_rot;
                        if (req_rot) begin
                            kind_n     = K_ROT;
                            cand_rot_n = {1'b0, piece_rot[1:0] + 2'd1};
                        end else if (req_left) begin
                            kind_n     = K_LEFT;
                            cand_col_n = base_col - 7'sd1;
                        end else if (req_right) begin
                            kind_n     = K_RIGHT;
                            cand_col_n = base_col + 7'sd1;
                        end else begin
                            kind_n     = K_DOWN;
                            cand_row_n = base_row + 7'sd1;
                        end
                    end
                end
            end
            SHAPE: state_n = QUERY;
            QUERY: begin
                if (oob) begin
                    coll_n  = 1'b1;
                    state_n = DECIDE;
                end else begin
                    brd_rd  = 1'b1;
                    brd_row = q_row[4:0];
                    brd_col = q_col[3:0];
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (brd_occ) begin
                    coll_n  = 1'b1;
                    state_n = DECIDE;
                end else if (blk == 2'd3) begin
                    state_n = DECIDE;
                end else begin
                    blk_n   = blk + 2'd1;
                    state_n = QUERY;
                end
            end
            DECIDE: begin
                if (!coll) begin
                    piece_row_n = cand_row[4:0];
                    piece_col_n = cand_col[3:0];
                    piece_rot_n = cand_rot;
                    if (kind == K_SPAWN) alive_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    case (kind)
                        K_DOWN: begin
                            // Lock and respawn stay inside one busy sequence.
                            lock       = 1'b1;
                            kind_n     = K_SPAWN;
                            cand_row_n = SR7;
                            cand_col_n = SC7;
                            cand_rot_n = 3'd0;
                            blk_n      = 2'd0;
                            coll_n     = 1'b0;
                            state_n    = SHAPE;
                        end
                        K_SPAWN: begin
                            game_over_n = 1'b1;
                            alive_n     = 1'b0;
                            state_n     = DEAD;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            DEAD:    state_n = DEAD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kind      <= K_SPAWN;
            blk       <= 2'd0;
            coll      <= 1'b0;
            cand_row  <= '0;
            cand_col  <= '0;
            cand_rot  <= 3'd0;
            piece_row <= 5'd0;
            piece_col <= 4'd0;
            piece_rot <= 3'd0;
            alive     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            kind      <= kind_n;
            blk       <= blk_n;
            coll      <= coll_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            cand_rot  <= cand_rot_n;
            piece_row <= piece_row_n;
            piece_col <= piece_col_n;
            piece_rot <= piece_rot_n;
            alive     <= alive_n;
            game_over <= game_over_n;
        end
    end

endmodule

// File: tb/tb_tetron_move_ctrl.sv
// Bench for tetron_move_ctrl: board model answers queries one cycle late,
// expected query addresses are queued per request and matched on each brd_rd.
module tb_tetron_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spawn = 1'b0, req_left = 1'b0, req_right = 1'b0, req_rot = 1'b0, req_down = 1'b0;
    logic       shp_active;
    logic [2:0] shp_rotation;
    logic [4:0] blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset;
    logic [4:0] blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset;
    logic       brd_rd;
    logic [4:0] brd_row;
    logic [3:0] brd_col;
    logic       brd_occ = 1'b0;
    logic [4:0] piece_row;
    logic [3:0] piece_col;
    logic [2:0] piece_rot;
    logic       alive, busy, lock, game_over;
    logic [2:0] state_dbg;

    int n_cmp = 0, n_fail = 0, rd_cnt = 0, lock_cnt = 0;
    int vo[4], ho[4];
    logic occ [0:31][0:15];
    logic occ_pend = 1'b0;
    logic [8:0] exp_q[$];

    assign blk1_voffset = 5'(vo[0]);
    assign blk2_voffset = 5'(vo[1]);
    assign blk3_voffset = 5'(vo[2]);
    assign blk4_voffset = 5'(vo[3]);
    assign blk1_hoffset = 5'(ho[0]);
    assign blk2_hoffset = 5'(ho[1]);
    assign blk3_hoffset = 5'(ho[2]);
    assign blk4_hoffset = 5'(ho[3]);

    tetron_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .spawn(spawn),
        .req_left(req_left), .req_right(req_right), .req_rot(req_rot), .req_down(req_down),
        .shp_active(shp_active), .shp_rotation(shp_rotation),
        .blk1_voffset(blk1_voffset), .blk2_voffset(blk2_voffset),
        .blk3_voffset(blk3_voffset), .blk4_voffset(blk4_voffset),
        .blk1_hoffset(blk1_hoffset), .blk2_hoffset(blk2_hoffset),
        .blk3_hoffset(blk3_hoffset), .blk4_hoffset(blk4_hoffset),
        .brd_rd(brd_rd), .brd_row(brd_row), .brd_col(brd_col), .brd_occ(brd_occ),
        .piece_row(piece_row), .piece_col(piece_col), .piece_rot(piece_rot),
        .alive(alive), .busy(busy), .lock(lock), .game_over(game_over),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Board model and query scoreboard; occupancy appears one cycle after brd_rd.
    always @(negedge clk) begin
        brd_occ  = occ_pend;
        occ_pend = 1'b0;
        if (brd_rd) begin
            rd_cnt++;
            occ_pend = occ[brd_row][brd_col];
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL query_addr: unexpected brd_rd row %0d col %0d", brd_row, brd_col);
            end else begin
                check("query_addr", {23'd0, brd_row, brd_col}, {23'd0, exp_q.pop_front()});
            end
        end
        if (lock) lock_cnt++;
    end

    // Expected addresses for one check: stop at the first off-board or occupied block.
    task automatic push_queries(input int row, input int col);
        int r, c;
        logic [8:0] a;
        for (int i = 0; i < 4; i++) begin
            r = row + vo[i];
            c = col + ho[i];
            if (r < 0 || r >= 20 || c < 0 || c >= 10) break;
            a = {r[4:0], c[3:0]};
            exp_q.push_back(a);
            if (occ[r][c]) break;
        end
    endtask

    task automatic issue(input logic [3:0] r);
        @(posedge clk);
        #1 {req_rot, req_left, req_right, req_down} = r;
        @(posedge clk);
        #1 {req_rot, req_left, req_right, req_down} = 4'b0000;
    endtask

    task automatic do_spawn();
        @(posedge clk);
        #1 spawn = 1'b1;
        @(posedge clk);
        #1 spawn = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'd0, busy}, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_shp_active"}, {31'd0, shp_active}, 0);
        check({tag, "_shp_rotation"}, {29'd0, shp_rotation}, 0);
        check({tag, "_brd_rd"}, {31'd0, brd_rd}, 0);
        check({tag, "_brd_addr"}, {23'd0, brd_row, brd_col}, 0);
        check({tag, "_piece"}, {20'd0, piece_row, piece_col, piece_rot}, 0);
        check({tag, "_alive"}, {31'd0, alive}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_lock"}, {31'd0, lock}, 0);
        check({tag, "_game_over"}, {31'd0, game_over}, 0);
        check({tag, "_state"}, {29'd0, state_dbg}, 0);
    endtask

    typedef struct {
        logic [3:0] req;      // {rot, left, right, down}
        int exp_row, exp_col, exp_rot, exp_shp, exp_nrd;
    } vec_t;
    vec_t tbl[16];

    initial begin
        int m_row, m_col, m_rot, cr, cc, crot, rd0, lk0;
        tbl[0]  = '{4'b1000, 1, 4, 1, 1, 4};
        tbl[1]  = '{4'b1000, 1, 4, 2, 2, 4};
        tbl[2]  = '{4'b1000, 1, 4, 3, 3, 4};
        tbl[3]  = '{4'b1000, 1, 4, 0, 0, 4};
        tbl[4]  = '{4'b0010, 1, 5, 0, 0, 4};
        tbl[5]  = '{4'b0010, 1, 6, 0, 0, 4};
        tbl[6]  = '{4'b0010, 1, 7, 0, 0, 4};
        tbl[7]  = '{4'b0010, 1, 8, 0, 0, 4};
        tbl[8]  = '{4'b0010, 1, 8, 0, 0, 2};
        tbl[9]  = '{4'b0100, 1, 7, 0, 0, 4};
        tbl[10] = '{4'b0001, 2, 7, 0, 0, 4};
        tbl[11] = '{4'b0001, 3, 7, 0, 0, 4};
        tbl[12] = '{4'b1111, 3, 7, 1, 1, 4};
        tbl[13] = '{4'b1000, 3, 7, 2, 2, 4};
        tbl[14] = '{4'b1000, 3, 7, 3, 3, 4};
        tbl[15] = '{4'b1000, 3, 7, 0, 0, 4};

        vo = '{0, 0, 0, -1};
        ho = '{0, -1, 1, 0};
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 16; c++) occ[r][c] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // First spawn: strobes at T+2,4,6,8, alive at T+11
        push_queries(1, 4);
        rd0 = rd_cnt;
        do_spawn();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("spawn_rd_t%0d", k), {31'd0, brd_rd}, (k >= 2 && k <= 8 && k % 2 == 0) ? 1 : 0);
            if (k == 10) check("spawn_alive_t10", {31'd0, alive}, 0);
        end
        check("spawn_alive", {31'd0, alive}, 1);
        check("spawn_busy", {31'd0, busy}, 0);
        check("spawn_piece", {20'd0, piece_row, piece_col, piece_rot}, {20'd0, 5'd1, 4'd4, 3'd0});
        check("spawn_nrd", rd_cnt - rd0, 4);
        m_row = 1; m_col = 4; m_rot = 0;

        // Table of moves on an empty board
        for (int i = 0; i < 16; i++) begin
            cr = m_row; cc = m_col; crot = m_rot;
            if (tbl[i].req[3])      crot = (m_rot + 1) % 4;
            else if (tbl[i].req[2]) cc = m_col - 1;
            else if (tbl[i].req[1]) cc = m_col + 1;
            else if (tbl[i].req[0]) cr = m_row + 1;
            push_queries(cr, cc);
            rd0 = rd_cnt;
            issue(tbl[i].req);
            @(negedge clk);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 1);
            check($sformatf("v%0d_shp_rot", i), {29'd0, shp_rotation}, tbl[i].exp_shp);
            wait_idle($sformatf("v%0d", i));
            check($sformatf("v%0d_row", i), {27'd0, piece_row}, tbl[i].exp_row);
            check($sformatf("v%0d_col", i), {28'd0, piece_col}, tbl[i].exp_col);
            check($sformatf("v%0d_rot", i), {29'd0, piece_rot}, tbl[i].exp_rot);
            check($sformatf("v%0d_idle_shp_rot", i), {29'd0, shp_rotation}, tbl[i].exp_rot);
            check($sformatf("v%0d_nrd", i), rd_cnt - rd0, tbl[i].exp_nrd);
            check($sformatf("v%0d_q_empty", i), exp_q.size(), 0);
            m_row = tbl[i].exp_row; m_col = tbl[i].exp_col; m_rot = tbl[i].exp_rot;
        end

        // Walk to the left wall with a point-shaped piece
        vo = '{0, 0, 0, 0};
        ho = '{0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            push_queries(3, 6 - i);
            issue(4'b0100);
            wait_idle("walk");
            check($sformatf("walk%0d_col", i), {28'd0, piece_col}, 6 - i);
        end

        // Left off the wall: no query at all, busy drops right after DECIDE
        ho[0] = -1;
        push_queries(3, -1);
        rd0 = rd_cnt;
        issue(4'b0100);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("wall_busy_decide", {31'd0, busy}, 1);
        @(negedge clk);
        check("wall_busy_after", {31'd0, busy}, 0);
        check("wall_col", {28'd0, piece_col}, 0);
        check("wall_row", {27'd0, piece_row}, 3);
        check("wall_nrd", rd_cnt - rd0, 0);

        // Down onto an occupied cell: abort after block 2, lock, respawn
        vo = '{0, 0, 0, -1};
        ho = '{0, 1, 2, 0};
        occ[4][1] = 1'b1;
        push_queries(4, 0);
        push_queries(1, 4);
        lk0 = lock_cnt;
        issue(4'b0001);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 6 || k == 5 || k == 7) check($sformatf("down_lock_t%0d", k), {31'd0, lock}, (k == 6) ? 1 : 0);
            if (k == 6) check("down_lock_row", {27'd0, piece_row}, 3);
            if (k == 8) req_left = 1'b1;
            if (k == 9) req_left = 1'b0;
        end
        wait_idle("down");
        check("down_lock_cnt", lock_cnt - lk0, 1);
        check("down_respawn", {20'd0, piece_row, piece_col, piece_rot}, {20'd0, 5'd1, 4'd4, 3'd0});
        check("down_alive", {31'd0, alive}, 1);
        check("down_q_empty", exp_q.size(), 0);

        // Locked piece blocks the spawn cell: game over
        occ[1][4] = 1'b1;
        push_queries(2, 4);
        push_queries(1, 4);
        lk0 = lock_cnt;
        issue(4'b0001);
        wait_idle("gameover");
        check("go_flag", {31'd0, game_over}, 1);
        check("go_alive", {31'd0, alive}, 0);
        check("go_shp_active", {31'd0, shp_active}, 0);
        check("go_lock_cnt", lock_cnt - lk0, 1);
        check("go_piece", {20'd0, piece_row, piece_col, piece_rot}, {20'd0, 5'd1, 4'd4, 3'd0});
        check("go_q_empty", exp_q.size(), 0);
        rd0 = rd_cnt;
        issue(4'b1000);
        do_spawn();
        repeat (15) @(negedge clk);
        check("dead_nrd", rd_cnt - rd0, 0);
        check("dead_busy", {31'd0, busy}, 0);
        check("dead_flag", {31'd0, game_over}, 1);
        check("dead_rot", {29'd0, piece_rot}, 0);

        // Reset out of DEAD, then reset again in the middle of a query
        rst_n = 1'b0;
        #1 check_zero("rst_dead");
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 16; c++) occ[r][c] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_queries(1, 4);
        do_spawn();
        @(negedge clk);
        @(negedge clk);
        check("midq_brd_rd", {31'd0, brd_rd}, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_midq");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_queries(1, 4);
        do_spawn();
        wait_idle("recover");
        check("recover_alive", {31'd0, alive}, 1);
        check("recover_piece", {20'd0, piece_row, piece_col, piece_rot}, {20'd0, 5'd1, 4'd4, 3'd0});
        check("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
